pong_game_ctrl: RTL
===================

# pong_game_ctrl

Game-level controller that sits directly downstream of the pong graphics engine. It consumes the engine's per-cycle `miss`/`hit` status and owns the match flow: new game, play, serve delay and game over. It keeps both players' scores in BCD for the score display and drives `gra_still` back to the engine to freeze and recenter the ball between points.

## Interface
Parameters:
- `WIN_SCORE`, 11: points needed to win; binary, legal range 1..99.
- `SERVE_TICKS`, 120: refresh ticks spent in NEWBALL before play resumes (2 s at 60 Hz); legal range 1..255.
- `OVER_TICKS`, 180: refresh ticks spent in OVER before returning to NEWGAME; legal range 1..255.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `tick`, in, 1: one-cycle pulse at frame refresh, the same 60 Hz tick the graphics engine uses.
- `start_btn`, in, 1: debounced level; a rising edge starts or serves.
- `miss`, in, 1: the ball has left the play field; level, and may stay high for several cycles.
- `hit`, in, 2: exit side. `hit[1]` = ball left past the right edge; `hit[0]` = ball left past the left edge.
- `gra_still`, out, 1: freeze and recenter the ball (to the engine).
- `state`, out, 2: current state. 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
- `score_l`, out, 8: left player score as BCD; [7:4] tens, [3:0] units.
- `score_r`, out, 8: right player score, same format.
- `winner`, out, 2: 00 none, 01 left player, 10 right player.
- `point`, out, 1: one-cycle pulse on each scored point.

## Operation
- All outputs are registered or decoded from registered state only (Moore); there are no combinational paths from input to output.
- Reset values: `state`=NEWGAME, `gra_still`=1, `score_l`=`score_r`=8'h00, `winner`=00, `point`=0, timer=0, and the start-edge register=0.
- `gra_still` = 1 in every state except PLAY.
- Start edge: `start_rise = start_btn & ~start_btn_q`. `start_btn_q` is updated every clock.

State transitions:
- NEWGAME -> PLAY on `start_rise`.
  - Scores and `winner` are cleared on that same edge.
- PLAY -> NEWBALL or OVER on `miss`=1.
  - Scorer: right player if `hit[0]`=1 (`hit[0]` has priority if both bits are set); otherwise left player.
  - The scorer's BCD score is incremented. Units 9 rolls to 0 with tens+1. Tens saturates at 9, so 99 stays 99.
  - If the new score equals `WIN_SCORE`: go to OVER, set `winner`, and load timer=`OVER_TICKS`.
  - Otherwise: go to NEWBALL and load timer=`SERVE_TICKS`.
  - `point` pulses for exactly one cycle.
- NEWBALL -> PLAY when a `tick` arrives with timer==1, or on `start_rise` (early serve). Otherwise the timer decrements on each `tick`.
- OVER -> NEWGAME when a `tick` arrives with timer==1. Otherwise the timer decrements on each `tick`. `start_rise` is ignored in OVER.

Input qualification:
- `miss`/`hit` are ignored in every state except PLAY. This makes each exit event score exactly once, even though `miss` stays high until the recentered ball is seen.
- A `start_rise` in PLAY is ignored.

## Timing
- `miss` sampled high at edge N (in PLAY):
  - At N: `state`=NEWBALL or OVER, `gra_still`=1, score updated, `point`=1.
  - At N+1: `point`=0.
- NEWBALL lasts exactly `SERVE_TICKS` ticks after entry, unless served early by `start_rise`. `gra_still` drops on the same edge that `state` becomes PLAY.
- If `tick` and `start_rise` coincide in NEWBALL, the result is PLAY (identical outcome either way).
- If `miss` arrives on the same edge PLAY is entered, it is not seen. It is sampled from the next edge onward.
- The timer is 8 bits and never wraps: it is only decremented while nonzero, and the exit condition is timer==1 with `tick`.
- Reset asserted mid-state returns every register to its reset value immediately. Scores are lost.

## Test plan
1. Reset, then `start_btn` 0->1: `state` goes 00->01 one cycle after the rise, `gra_still` goes 1->0, and both scores are 8'h00.
2. In PLAY, hold `miss`=1, `hit`=2'b01 for 5 cycles: `score_r`=8'h01, `score_l`=8'h00, a single `point` pulse, and `state`=10.
3. Continuing from scenario 2, apply 120 ticks with no button: `state` returns to 01 on the 120th tick and not before. Repeat with `start_rise` after 3 ticks: PLAY is reached on the cycle after the rise.
4. Nine left points with `hit`=2'b10, then one more: `score_l` steps through 8'h09 -> 8'h10 (BCD rollover).
5. With `WIN_SCORE`=3, score three right points: `state`=11, `winner`=10. `start_rise` is ignored. After 180 ticks, `state`=00. A subsequent `start_rise` clears scores and `winner`.
6. `miss` with `hit`=2'b11: the right player scores. Assert `reset` mid-NEWBALL: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match flow for the pong game.
// Turns the graphics engine's miss/hit status into BCD scores, a serve delay,
// game over and new game. It also freezes the ball between points.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_TICKS = 120,
    parameter int OVER_TICKS  = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       miss,
    input  logic [1:0] hit,
    output logic       gra_still,
    output logic [1:0] state,
    output logic [7:0] score_l,
    output logic [7:0] score_r,
    output logic [1:0] winner,
    output logic       point
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [7:0] WIN_B   = 8'(WIN_SCORE);
    localparam logic [7:0] SERVE_B = 8'(SERVE_TICKS);
    localparam logic [7:0] OVER_B  = 8'(OVER_TICKS);

    state_t     state_reg;
    logic [7:0] timer_reg;
    logic       start_btn_q;

    logic       start_rise;
    logic       score_right;
    logic [7:0] new_score;
    logic       win_now;

    // BCD +1. Units roll into tens. The score stops at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        else if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        else
            return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // Converts a two-digit BCD value to binary so it can be compared with WIN_SCORE.
    function automatic logic [7:0] bcd_to_bin(input logic [7:0] s);
        logic [7:0] tens;
        tens = {4'd0, s[7:4]};
        return tens * 8'd10 + {4'd0, s[3:0]};
    endfunction

    assign start_rise = start_btn & ~start_btn_q;

    // The ball left past the left edge, so the right player scores. hit[0]
    // takes priority, so 2'b11 also counts as a right-player point.
    assign score_right = (hit == 2'b01) | (hit == 2'b11);

    assign new_score = bcd_inc(score_right ? score_r : score_l);
    assign win_now   = (bcd_to_bin(new_score) == WIN_B);

    assign state = state_reg;

    // Match state machine. All outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= NEWGAME;
            timer_reg   <= 8'd0;
            start_btn_q <= 1'b0;
            gra_still   <= 1'b1;
            score_l     <= 8'h00;
            score_r     <= 8'h00;
            winner      <= 2'b00;
            point       <= 1'b0;
        end else begin
            start_btn_q <= start_btn;
            point       <= 1'b0;
            case (state_reg)
                NEWGAME: begin
                    if (start_rise) begin
                        state_reg <= PLAY;
                        gra_still <= 1'b0;
                        score_l   <= 8'h00;
                        score_r   <= 8'h00;
                        winner    <= 2'b00;
                    end
                end
                PLAY: begin
                    // miss stays high until the ball is recentered. Leaving PLAY
                    // here makes sure each exit is scored only once.
                    if (miss) begin
                        point     <= 1'b1;
                        gra_still <= 1'b1;
                        if (score_right)
                            score_r <= new_score;
                        else
                            score_l <= new_score;
                        if (win_now) begin
                            state_reg <= OVER;
                            winner    <= score_right ? 2'b10 : 2'b01;
                            timer_reg <= OVER_B;
                        end else begin
                            state_reg <= NEWBALL;
                            timer_reg <= SERVE_B;
                        end
                    end
                end
                NEWBALL: begin
                    if (start_rise || (tick && timer_reg == 8'd1)) begin
                        state_reg <= PLAY;
                        gra_still <= 1'b0;
                    end else if (tick && timer_reg != 8'd0) begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                OVER: begin
                    if (tick && timer_reg == 8'd1)
                        state_reg <= NEWGAME;
                    else if (tick && timer_reg != 8'd0)
                        timer_reg <= timer_reg - 8'd1;
                end
                default: state_reg <= NEWGAME;
            endcase
        end
    end

endmodule
